i2c_regbank_if: RTL

//  Parametrised successor to the write-only I2C register front end. Sits between
//  the i2c_slave core (SCL-domain start/stop/data_vld/r_w/data strobes) and the
//  clk-domain register bank. Adds N-bit addressing with an address bound, pointer

---
 rtl/i2c_regbank_if.sv | 136 +++++++++++++
 1 files changed

// File: rtl/i2c_regbank_if.sv
// i2c_regbank_if: clk-domain bridge from the i2c_slave core strobes to the register bank.
// Optional read-back path is enabled by defining I2C_REGBANK_READBACK_EN.
module i2c_regbank_if #(
   parameter int REGBITS  = 3,
   parameter int NUM_REGS = 8,
   parameter bit AUTOINC  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i2c_start,
   input  logic               i2c_stop,
   input  logic               i2c_data_vld,
   input  logic               i2c_rw,
   input  logic [7:0]         i2c_data_out,
   output logic [7:0]         i2c_data_in,
   output logic [REGBITS-1:0] wr_addr,
   output logic [7:0]         wr_data,
   output logic               wr_valid,
   output logic [REGBITS-1:0] rd_addr,
   input  logic [7:0]         rd_data,
   output logic               err_oob,
   input  logic               err_clr
);

   typedef enum logic [2:0] {
      IDLE, PTR_WAIT, PTR_LATCH, WR_WAIT, WR_LATCH, RD_WAIT, RD_NEXT
   } state_t;

   localparam logic [REGBITS-1:0] LAST = REGBITS'(NUM_REGS - 1);

   state_t             state;
   logic [1:0]         start_q, stop_q, vld_q, rw_q;
   logic               start_s, stop_s, vld_s, rw_s;
   logic [REGBITS-1:0] ptr, ptr_nxt;
   logic               in_rng, err_set;

`ifdef I2C_REGBANK_READBACK_EN
   localparam state_t RD_ENTRY = RD_WAIT;
   logic [7:0] rd_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_byte <= 8'h00;
      else if (state == RD_WAIT) rd_byte <= in_rng ? rd_data : 8'h00;
   end

   assign i2c_data_in = rd_byte;
`else
   localparam state_t RD_ENTRY = IDLE;
   logic unused_rd;
   assign unused_rd   = ^rd_data;
   assign i2c_data_in = 8'h00;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= 2'b00;
         stop_q  <= 2'b00;
         vld_q   <= 2'b00;
         rw_q    <= 2'b00;
      end else begin
         start_q <= {start_q[0], i2c_start};
         stop_q  <= {stop_q[0], i2c_stop};
         vld_q   <= {vld_q[0], i2c_data_vld};
         rw_q    <= {rw_q[0], i2c_rw};
      end
   end

   assign start_s = start_q[1];
   assign stop_s  = stop_q[1];
   assign vld_s   = vld_q[1];
   assign rw_s    = rw_q[1];

   assign rd_addr = ptr;
   assign in_rng  = 32'(ptr) < NUM_REGS;

   // Wrap at NUM_REGS; an out-of-range pointer just rolls over the field width.
   always_comb begin
      ptr_nxt = ptr;
      if (AUTOINC) ptr_nxt = (ptr == LAST) ? '0 : ptr + REGBITS'(1);
   end

   assign err_set = !start_s && !stop_s && !vld_s && !in_rng &&
                    (state == WR_LATCH || state == RD_NEXT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         wr_addr  <= '0;
         wr_data  <= 8'h00;
         wr_valid <= 1'b0;
         err_oob  <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         if (err_clr) err_oob <= 1'b0;
         else if (err_set) err_oob <= 1'b1;

         if (start_s) begin
            state <= rw_s ? RD_ENTRY : PTR_WAIT;
         end else if (stop_s) begin
            state <= IDLE;
         end else begin
            unique case (state)
               PTR_WAIT: if (vld_s) state <= PTR_LATCH;
               PTR_LATCH: begin
                  if (!vld_s) begin
                     ptr   <= i2c_data_out[REGBITS-1:0];
                     state <= WR_WAIT;
                  end
               end
               WR_WAIT: if (vld_s) state <= WR_LATCH;
               WR_LATCH: begin
                  if (!vld_s) begin
                     if (in_rng) begin
                        wr_addr  <= ptr;
                        wr_data  <= i2c_data_out;
                        wr_valid <= 1'b1;
                     end
                     ptr   <= ptr_nxt;
                     state <= WR_WAIT;
                  end
               end
               RD_WAIT: if (vld_s) state <= RD_NEXT;
               RD_NEXT: begin
                  if (!vld_s) begin
                     ptr   <= ptr_nxt;
                     state <= RD_WAIT;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
